// File: rtl/ext_sram_ctrl.sv
// Single-outstanding request/response initiator for the board's 32-bit asynchronous SRAM.
// Optional read-to-write bus turnaround cycle: define SRAM_CTRL_TURNAROUND_EN.
module ext_sram_ctrl #(
  parameter int unsigned A_MSB    = 23,
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned WR_SETUP = 1,
  parameter int unsigned WR_PULSE = 2,
  parameter int unsigned WR_HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [A_MSB-2:0] req_addr,
  input  logic [3:0]       req_be,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             sram_nce,
  output logic             sram_noe,
  output logic [3:0]       sram_nwe,
  output logic             sram_ce2,
  output logic [A_MSB:2]   sram_a,
  inout  wire logic [31:0] sram_d
);

  // Phase counters load N-1 so a phase lasts N cycles; zero settings clamp to one cycle.
  localparam logic [3:0] RD_CNT    = 4'(RD_WAIT);
  localparam logic [3:0] SETUP_CNT = 4'((WR_SETUP == 0) ? 0 : WR_SETUP - 1);
  localparam logic [3:0] PULSE_CNT = 4'((WR_PULSE == 0) ? 0 : WR_PULSE - 1);
  localparam logic [3:0] HOLD_CNT  = 4'((WR_HOLD == 0) ? 0 : WR_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WS,
    WP,
    WH
`ifdef SRAM_CTRL_TURNAROUND_EN
    , TURN
`endif
  } state_t;

  state_t             state, stateNext;
  logic [3:0]         cnt, cntNext;
  logic               nceNext, noeNext, dOe, dOeNext, rspValidNext;
  logic [3:0]         nweNext, beReg, beNext;
  logic [31:0]        wdataReg, wdataNext, rdataNext;
  logic [A_MSB-2:0]   addrNext;

  assign req_ready = (state == IDLE);
  assign sram_d    = dOe ? wdataReg : {32{1'bz}};

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_nce  <= 1'b1;
      sram_noe  <= 1'b1;
      sram_nwe  <= '1;
      dOe       <= 1'b0;
      sram_a    <= '0;
      beReg     <= '0;
      wdataReg  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sram_ce2  <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      sram_nce  <= nceNext;
      sram_noe  <= noeNext;
      sram_nwe  <= nweNext;
      dOe       <= dOeNext;
      sram_a    <= addrNext;
      beReg     <= beNext;
      wdataReg  <= wdataNext;
      rsp_valid <= rspValidNext;
      rsp_rdata <= rdataNext;
      sram_ce2  <= 1'b1;
    end
  end

  // Next values are for registered pins: each branch sets what the pins show after this edge.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    nceNext      = sram_nce;
    noeNext      = sram_noe;
    nweNext      = sram_nwe;
    dOeNext      = dOe;
    addrNext     = sram_a;
    beNext       = beReg;
    wdataNext    = wdataReg;
    rspValidNext = 1'b0;
    rdataNext    = rsp_rdata;
    case (state)
      IDLE: begin
        nceNext = 1'b1;
        noeNext = 1'b1;
        nweNext = '1;
        dOeNext = 1'b0;
        if (req_valid) begin
          addrNext  = req_addr;
          beNext    = req_be;
          wdataNext = req_wdata;
          nceNext   = 1'b0;
          if (req_we) begin
            stateNext = WS;
            cntNext   = SETUP_CNT;
            dOeNext   = 1'b1;
          end else begin
            stateNext = RD;
            cntNext   = RD_CNT;
            noeNext   = 1'b0;
          end
        end
      end
      RD: begin
        if (cnt == 4'd0) begin
          rdataNext    = sram_d;
          rspValidNext = 1'b1;
          nceNext      = 1'b1;
          noeNext      = 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
          stateNext    = TURN;
`else
          stateNext    = IDLE;
`endif
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      WS: begin
        if (cnt == 4'd0) begin
          stateNext = WP;
          cntNext   = PULSE_CNT;
          nweNext   = ~beReg;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      WP: begin
        if (cnt == 4'd0) begin
          stateNext = WH;
          cntNext   = HOLD_CNT;
          nweNext   = '1;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      WH: begin
        if (cnt == 4'd0) begin
          stateNext = IDLE;
          nceNext   = 1'b1;
          dOeNext   = 1'b0;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
`ifdef SRAM_CTRL_TURNAROUND_EN
      TURN: stateNext = IDLE;
`endif
      default: begin
        stateNext = IDLE;
        nceNext   = 1'b1;
        noeNext   = 1'b1;
        nweNext   = '1;
        dOeNext   = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/ext_sram_ctrl.md
# ext_sram_ctrl

Synchronous bus-side initiator that drives the board's 32-bit asynchronous SRAM (`nCE`/`nOE`/`nWE[3:0]`/`A`/`D`/`CE2`) from a single-outstanding request/response port. It converts one accepted read or write request into a programmable-wait-state SRAM strobe sequence. It samples read data at a fixed cycle and returns it on a one-cycle response pulse. The block sits between the ARC 600 external memory bus logic and the off-chip SRAM pins.

## Interface
- `A_MSB`, 23: MSB of word address; `sram_a` is `[A_MSB:2]`.
- `RD_WAIT`, 2: extra read cycles beyond one; range 0..15.
- `WR_SETUP`, 1: address/data setup cycles before `nWE` falls; range 1..15, 0 treated as 1.
- `WR_PULSE`, 2: `nWE` low cycles; range 1..15, 0 treated as 1.
- `WR_HOLD`, 1: cycles after `nWE` rises with `nCE`/`D` held; range 1..15, 0 treated as 1.

Ports:
- `clk`  in  1  sole clock.
- `rst_a`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  = (state==IDLE); accept on `req_valid & req_ready`.
- `req_we`  in  1  1=write, 0=read.
- `req_addr`  in  `A_MSB-1`  word address.
- `req_be`  in  4  write byte enables, bit n = `D[8n+7:8n]`.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle read-data pulse.
- `rsp_rdata`  out  32  read data, held until next read completes.
- `sram_nce`, `sram_noe`  out  1  low-active strobes.
- `sram_nwe`  out  4  low-active per-byte write strobes.
- `sram_ce2`  out  1  high-active chip enable.
- `sram_a`  out  `[A_MSB:2]`  address.
- `sram_d`  inout  32  data bus; driven only in write states.

## Operation
- States: IDLE, RD, WS, WP, WH, TURN (TURN exists only with the macro). 4-bit down-counter `cnt`.
- IDLE: all strobes high, `sram_d` high-Z. On accept, register `req_addr`→`sram_a`, `req_be`, and `req_wdata`. Go to RD with `cnt=RD_WAIT` if read, or to WS with `cnt=WR_SETUP-1` if write.
- RD: `nCE=0`, `nOE=0`, `nWE=F`. Decrement `cnt`. At the edge where `cnt==0`: capture `sram_d`→`rsp_rdata`, set `rsp_valid=1` for one cycle, deassert `nCE`/`nOE`, and go to TURN or IDLE.
- WS: `nCE=0`, `nOE=1`, `nWE=F`, `sram_d` driven. At `cnt==0`, go to WP with `cnt=WR_PULSE-1`.
- WP: `nWE=~be`. At `cnt==0`, go to WH with `cnt=WR_HOLD-1`.
- WH: `nWE=F`, `nCE=0`, `D` still driven. At `cnt==0`, go to IDLE and release `D`.
- Writes produce no response. `req_be=0` runs the full sequence with `nWE` never low.
- All SRAM outputs are registered; they are not glitch-free combinational decodes.
- Invariant: `sram_d` is never driven while `sram_noe==0`.
- `sram_ce2`: reset 0, then 1 from the first edge after reset release.

## Timing
- Reset values: `nCE=1`, `nOE=1`, `nWE=4'hF`, `sram_a=0`, `sram_d`=Z, `sram_ce2=0`, `rsp_valid=0`, `rsp_rdata=0`, state IDLE (`req_ready=1`).
- Read: accepted at edge E0. Strobes are low from E0 to E_{RD_WAIT+1}. `rsp_valid` is high in the cycle after E_{RD_WAIT+1}. Read occupancy is RD_WAIT+1 cycles plus 1 cycle for TURN if enabled.
- Write: accepted at E0. Occupancy is WR_SETUP+WR_PULSE+WR_HOLD cycles, then IDLE.
- `req_ready` is low in every non-IDLE state. Back-to-back requests: the next request is accepted in the first IDLE cycle.
- Reset mid-operation: strobes deassert and `D` goes to Z asynchronously. The transaction is dropped and no `rsp_valid` is issued.

## Configuration
- `SRAM_CTRL_TURNAROUND_EN` defined: after every read, one TURN cycle follows with all strobes high, `D`=Z, and `req_ready=0`. This gives bus turnaround before a following write drives `D`.
- Macro undefined: RD returns directly to IDLE, and TURN is not synthesized.

## Test plan
- Reset: hold `rst_a` and toggle `clk` → `nCE=1`, `nOE=1`, `nWE=F`, `D`=Z, `rsp_valid=0`. After release, `sram_ce2=1` at the first edge.
- Read with SRAM model preloaded `0x12345678` at word 0x40, default params → `nOE` low for exactly 3 cycles, `rsp_valid` pulses once, `rsp_rdata=0x12345678`.
- Write addr 0x80, data `0xA5A5_5A5A`, `be=4'b0101` → 1 setup cycle, then `nWE=4'b1010` for 2 cycles, then 1 hold cycle. Readback gives `0x??A5??5A` with untouched bytes preserved.
- Read immediately followed by write, both with macro defined and undefined → 1 TURN cycle versus 0 between `nOE` rising and `D` driven. `D` is never driven while `nOE=0`.
- Assert `rst_a` during the WP cycle of a write → `nWE` returns to F asynchronously, no `rsp_valid`, `req_ready=1` after release.
- `RD_WAIT=0`, `WR_PULSE=0` → read strobes last 1 cycle and response follows. `nWE` is low for 1 cycle (0 clamped to 1).
